// File: rtl/rpn_sequencer.sv
// rpn_sequencer -- program sequencer for the 8-bit queue calculator.
//
// Holds a DEPTH x 11-bit program memory ({op[2:0], imm[7:0]}) loaded by the
// host while idle or done. On start it streams the program into the
// calculator's apply/op/in port, one word per cycle (RUN) or one word per
// step pulse (PAUSE). Execution ends on a HALT word (op 7), after the last
// memory word (via FINAL), or when the calculator's valid drops (ERROR).
//
// Ports:
//   clk, rst              clock (rising edge), async active-high reset
//   start, step_mode      begin execution from pc 0; step_mode picks PAUSE
//   step                  issue one instruction while in PAUSE
//   prog_we/addr/data     program write port (IDLE/DONE only)
//   calc_valid/empty/tail calculator status inputs
//   calc_apply/op/in      calculator command outputs
//   busy, done, error     RUN|PAUSE, DONE, ERROR state flags
//   pc                    address of the next instruction
//   result                calc_tail captured on completion
//   issued                applied-instruction count, saturating at 255
module rpn_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          step_mode,
  input  logic          step,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [10:0]   prog_data,
  input  logic          calc_valid,
  input  logic          calc_empty,
  input  logic [7:0]    calc_tail,
  output logic          calc_apply,
  output logic [2:0]    calc_op,
  output logic [7:0]    calc_in,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [AW-1:0] pc,
  output logic [7:0]    result,
  output logic [7:0]    issued
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_FINAL,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [2:0] OP_HALT = 3'd7;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [7:0]    issued_q, issued_d;
  logic [7:0]    result_q, result_d;

  logic [10:0]   mem [DEPTH];

  logic [10:0]   word;
  logic [2:0]    op;
  logic          is_halt;
  logic          can_cfg;
  logic          addr_ok;
  logic          issue_cycle;
  logic          last_addr;

  // calc_empty is part of the calculator status bundle but the sequencer
  // does not need it; kept on the port list for drop-in wiring.
  logic          unused_calc_empty;
  assign unused_calc_empty = calc_empty;

  assign word    = mem[pc_q];
  assign op      = word[10:8];
  assign is_halt = (op == OP_HALT);

  assign can_cfg     = (state_q == S_IDLE) || (state_q == S_DONE);
  assign addr_ok     = ({1'b0, prog_addr} < (AW+1)'(DEPTH));
  assign issue_cycle = (state_q == S_RUN) || ((state_q == S_PAUSE) && step);
  assign last_addr   = (pc_q == AW'(DEPTH - 1));

  // Program memory: synchronous write, asynchronous read, never reset.
  // A write coinciding with start in DONE lands before the first fetch.
  always_ff @(posedge clk) begin
    if (prog_we && can_cfg && addr_ok) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // calc_valid is a register output inside the calculator, so feeding it
  // straight into calc_apply creates no combinational loop.
  assign calc_apply = issue_cycle && !is_halt && calc_valid;
  assign calc_op    = op;
  assign calc_in    = word[7:0];

  assign busy   = (state_q == S_RUN) || (state_q == S_PAUSE);
  assign done   = (state_q == S_DONE);
  assign error  = (state_q == S_ERROR);
  assign pc     = pc_q;
  assign result = result_q;
  assign issued = issued_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      issued_q <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      issued_q <= issued_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    issued_d = issued_q;
    result_d = result_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = step_mode ? S_PAUSE : S_RUN;
          pc_d     = '0;
          issued_d = '0;
        end
      end

      S_RUN, S_PAUSE: begin
        // issue_cycle is always true in RUN; in PAUSE it gates on step.
        if (issue_cycle) begin
          if (!calc_valid) begin
            // Fault from the previous apply: suppress this instruction.
            state_d = S_ERROR;
          end else if (is_halt) begin
            state_d  = S_DONE;
            result_d = calc_tail;
          end else begin
            issued_d = (issued_q == 8'hFF) ? issued_q : issued_q + 8'd1;
            if (last_addr) begin
              // Last word applied: pc stays put, FINAL collects the result.
              state_d = S_FINAL;
            end else begin
              pc_d = pc_q + AW'(1);
            end
          end
        end
      end

      S_FINAL: begin
        result_d = calc_tail;
        state_d  = calc_valid ? S_DONE : S_ERROR;
      end

      S_ERROR: begin
        state_d = S_ERROR;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rpn_sequencer.sv
// Testbench for rpn_sequencer: directed programs against a small stack-style
// calculator model. Expected apply words go into a queue; a monitor pops and
// compares on every calc_apply. Completion state is checked after each run.
module tb_rpn_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, step_mode, step, prog_we;
  logic [3:0]  prog_addr;
  logic [10:0] prog_data;
  logic        calc_valid, calc_empty;
  logic [7:0]  calc_tail;
  logic        calc_apply;
  logic [2:0]  calc_op;
  logic [7:0]  calc_in;
  logic        busy, done, error;
  logic [3:0]  pc;
  logic [7:0]  result, issued;

  int passed = 0;
  int total  = 0;
  int n_apply = 0;
  logic [10:0] exp_q [$];

  always #5 clk = ~clk;

  rpn_sequencer #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .step(step),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .calc_valid(calc_valid), .calc_empty(calc_empty), .calc_tail(calc_tail),
    .calc_apply(calc_apply), .calc_op(calc_op), .calc_in(calc_in),
    .busy(busy), .done(done), .error(error), .pc(pc),
    .result(result), .issued(issued)
  );

  // Calculator model: op0 push imm, op2 add top two, op5 top = imm / top.
  // Underflow or divide by zero clears valid (sticky until rst).
  logic [7:0] stk [32];
  int         cnt;
  logic       m_valid;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 0;
      m_valid <= 1'b1;
    end else if (calc_apply && m_valid) begin
      case (calc_op)
        3'd0: begin
          stk[cnt] <= calc_in;
          cnt <= cnt + 1;
        end
        3'd2: begin
          if (cnt < 2) m_valid <= 1'b0;
          else begin
            stk[cnt-2] <= stk[cnt-2] + stk[cnt-1];
            cnt <= cnt - 1;
          end
        end
        3'd5: begin
          if (cnt < 1 || stk[cnt-1] == 8'd0) m_valid <= 1'b0;
          else stk[cnt-1] <= calc_in / stk[cnt-1];
        end
        default: m_valid <= 1'b0;
      endcase
    end
  end
  assign calc_valid = m_valid;
  assign calc_empty = (cnt == 0);
  assign calc_tail  = (cnt == 0) ? 8'd0 : stk[cnt-1];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: every apply must match the next expected word.
  always @(negedge clk) begin
    if (calc_apply) begin
      n_apply++;
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_apply: got %03h expected none", {calc_op, calc_in});
      end else begin
        chk("apply_word", int'({calc_op, calc_in}), int'(exp_q.pop_front()));
      end
    end
  end

  function automatic logic [10:0] w(input logic [2:0] op, input logic [7:0] imm);
    return {op, imm};
  endfunction

  logic [10:0] prog [16];
  int          plen;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    #1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic load_prog();
    for (int i = 0; i < plen; i++) begin
      prog_we = 1'b1; prog_addr = 4'(i); prog_data = prog[i];
      tick();
    end
    prog_we = 1'b0;
  endtask

  task automatic pulse_start(input logic sm);
    start = 1'b1; step_mode = sm;
    tick();
    start = 1'b0;
  endtask

  // Counts edges after the start edge until done/error; 0 means timeout.
  task automatic wait_end(input int budget, output int n);
    n = 0;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (done || error) begin
        n = i;
        break;
      end
    end
    if (n == 0) chk("timeout", 0, 1);
  endtask

  task automatic add_prog();
    prog[0] = w(3'd0, 8'd7); prog[1] = w(3'd0, 8'd5);
    prog[2] = w(3'd2, 8'd0); prog[3] = w(3'd7, 8'd0);
    plen = 4;
  endtask

  task automatic push_add_exp();
    exp_q.push_back(w(3'd0, 8'd7));
    exp_q.push_back(w(3'd0, 8'd5));
    exp_q.push_back(w(3'd2, 8'd0));
  endtask

  int n, a0;

  initial begin
    rst = 1'b0; start = 1'b0; step_mode = 1'b0; step = 1'b0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    do_reset();

    // Reset values
    chk("rst_busy", busy, 0);   chk("rst_done", done, 0);
    chk("rst_error", error, 0); chk("rst_apply", calc_apply, 0);
    chk("rst_pc", pc, 0);       chk("rst_issued", issued, 0);
    chk("rst_result", result, 0);

    // Add program in RUN
    add_prog(); load_prog();
    push_add_exp();
    pulse_start(1'b0);
    chk("run_busy", busy, 1);
    wait_end(20, n);
    chk("run_latency", n, 4);
    chk("run_done", done, 1);   chk("run_error", error, 0);
    chk("run_result", result, 12);
    chk("run_issued", issued, 3);
    chk("run_pc", pc, 3);
    chk("run_pending", exp_q.size(), 0);

    // Fault: push 0, 100/0 -> error, push 9 suppressed
    do_reset();
    prog[0] = w(3'd0, 8'd0); prog[1] = w(3'd5, 8'd100);
    prog[2] = w(3'd0, 8'd9); prog[3] = w(3'd7, 8'd0);
    plen = 4; load_prog();
    exp_q.push_back(w(3'd0, 8'd0));
    exp_q.push_back(w(3'd5, 8'd100));
    pulse_start(1'b0);
    wait_end(20, n);
    chk("err_error", error, 1); chk("err_done", done, 0);
    chk("err_pc", pc, 2);       chk("err_issued", issued, 2);
    chk("err_pending", exp_q.size(), 0);
    pulse_start(1'b0);
    tick(); tick(); tick();
    chk("err_sticky", error, 1); chk("err_sticky_busy", busy, 0);
    chk("err_sticky_pc", pc, 2);

    // Step mode
    do_reset();
    add_prog(); load_prog();
    push_add_exp();
    pulse_start(1'b1);
    a0 = n_apply;
    for (int i = 0; i < 5; i++) tick();
    chk("step_hold_apply", n_apply - a0, 0);
    chk("step_hold_busy", busy, 1);
    chk("step_hold_issued", issued, 0);
    for (int i = 0; i < 3; i++) begin
      a0 = n_apply;
      step = 1'b1; tick(); step = 1'b0;
      tick();
      chk("step_one_apply", n_apply - a0, 1);
    end
    chk("step_pre_halt_busy", busy, 1);
    step = 1'b1; tick(); step = 1'b0;
    chk("step_done", done, 1);
    chk("step_result", result, 12);
    chk("step_pending", exp_q.size(), 0);

    // Full memory, no HALT -> FINAL
    do_reset();
    for (int i = 0; i < 16; i++) begin
      prog[i] = w(3'd0, 8'(i + 1));
      exp_q.push_back(w(3'd0, 8'(i + 1)));
    end
    plen = 16; load_prog();
    pulse_start(1'b0);
    wait_end(40, n);
    chk("full_latency", n, 17);
    chk("full_done", done, 1);
    chk("full_result", result, 16);
    chk("full_issued", issued, 16);
    chk("full_pending", exp_q.size(), 0);

    // prog_we during RUN is dropped; rerun from DONE reads original program
    do_reset();
    add_prog(); load_prog();
    push_add_exp();
    pulse_start(1'b0);
    prog_we = 1'b1; prog_addr = 4'd2; prog_data = w(3'd0, 8'h33);
    tick();
    prog_we = 1'b0;
    wait_end(20, n);
    chk("we_run_result", result, 12);
    push_add_exp();
    pulse_start(1'b0);
    wait_end(20, n);
    chk("we_readback_result", result, 12);
    chk("we_readback_pending", exp_q.size(), 0);

    // In DONE, start + prog_we same cycle: first fetch sees the new word
    exp_q.push_back(w(3'd0, 8'd2));
    exp_q.push_back(w(3'd0, 8'd5));
    exp_q.push_back(w(3'd2, 8'd0));
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = w(3'd0, 8'd2);
    pulse_start(1'b0);
    prog_we = 1'b0;
    wait_end(20, n);
    chk("prec_result", result, 7);
    chk("prec_pending", exp_q.size(), 0);

    // Async reset during the 2nd apply
    do_reset();
    add_prog(); load_prog();
    exp_q.push_back(w(3'd0, 8'd7));
    pulse_start(1'b0);
    tick();
    chk("mid_apply_before", calc_apply, 1);
    rst = 1'b1;
    #1;
    chk("mid_apply", calc_apply, 0); chk("mid_busy", busy, 0);
    chk("mid_pc", pc, 0);            chk("mid_issued", issued, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("mid_pending", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
